write_rr_arbiter: RTL and testbench



---
 rtl/write_rr_arbiter.sv | 104 ++++++++++
 tb/tb_write_rr_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/write_rr_arbiter.sv
// rtl/write_rr_arbiter.sv - round-robin write request arbiter with per-packet lock and burst cap
module write_rr_arbiter #(
    parameter int num_of_ports = 16,
    parameter int max_burst    = 64,
    parameter int cnt_width    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [num_of_ports-1:0] req,
    input  logic [num_of_ports-1:0] last,
    input  logic                    ready,
    output logic [3:0]              select,
    output logic                    enable,
    output logic [num_of_ports-1:0] grant,
    output logic [num_of_ports-1:0] ack,
    output logic                    busy
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    localparam int burst_lim_i = (max_burst == 0) ? 0 : max_burst - 1;
    localparam logic [cnt_width-1:0] burst_lim = burst_lim_i[cnt_width-1:0];
    localparam logic [num_of_ports-1:0] one_hot_base = {{(num_of_ports-1){1'b0}}, 1'b1};

    state_t                  state, state_next;
    logic [3:0]              pointer, pointer_next;
    logic [3:0]              select_next;
    logic [num_of_ports-1:0] grant_next;
    logic                    busy_next;
    logic [cnt_width-1:0]    beat_cnt, cnt_next;
    logic [3:0]              pick;
    logic                    found;
    logic                    release_now;

    // Rotating-priority search starting at the pointer, wrapping 15 -> 0.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < num_of_ports; i++) begin
            if (!found && req[pointer + 4'(i)]) begin
                pick  = pointer + 4'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        select_next  = select;
        grant_next   = grant;
        busy_next    = busy;
        pointer_next = pointer;
        cnt_next     = beat_cnt;
        enable       = 1'b0;
        release_now  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next  = HOLD;
                    select_next = pick;
                    grant_next  = one_hot_base << pick;
                    busy_next   = 1'b1;
                    cnt_next    = '0;
                end
            end
            HOLD: begin
                enable      = req[select] & ready;
                release_now = enable &
                              (last[select] || ((max_burst != 0) && (beat_cnt == burst_lim)));
                if (release_now) begin
                    state_next   = IDLE;
                    grant_next   = '0;
                    busy_next    = 1'b0;
                    pointer_next = select + 4'd1;
                    cnt_next     = '0;
                end else if (enable && (beat_cnt != '1)) begin
                    cnt_next = beat_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            select   <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            pointer  <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            select   <= select_next;
            grant    <= grant_next;
            busy     <= busy_next;
            pointer  <= pointer_next;
            beat_cnt <= cnt_next;
        end
    end

    assign ack = grant & {num_of_ports{enable}};

endmodule

// File: tb/tb_write_rr_arbiter.sv
// tb/tb_write_rr_arbiter.sv - directed bench for write_rr_arbiter
module tb_write_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;
    logic [15:0] last = '0;
    logic        ready = 1'b0;

    logic [3:0]  select, select_c;
    logic        enable, enable_c;
    logic [15:0] grant, grant_c;
    logic [15:0] ack, ack_c;
    logic        busy, busy_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    write_rr_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .last(last), .ready(ready),
        .select(select), .enable(enable), .grant(grant), .ack(ack), .busy(busy)
    );

    write_rr_arbiter #(.max_burst(4)) dut_cap (
        .clk(clk), .rst(rst), .req(req), .last(last), .ready(ready),
        .select(select_c), .enable(enable_c), .grant(grant_c), .ack(ack_c), .busy(busy_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs just after the edge; outputs are checked 2 time units later.
    task automatic step(input logic [15:0] r, input logic [15:0] l, input logic rd, input logic rs);
        @(posedge clk);
        #1;
        req = r; last = l; ready = rd; rst = rs;
        #1;
    endtask

    initial begin
        logic [3:0]  rr_order [6];
        logic        rdy_pat  [7];
        logic [15:0] cap_exp  [12];
        int          ack_cnt;

        rr_order = '{4'd0, 4'd1, 4'd15, 4'd0, 4'd1, 4'd15};
        rdy_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        cap_exp  = '{16'h0000, 16'h0080, 16'h0080, 16'h0080, 16'h0080, 16'h0000,
                     16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0080};

        // Reset and idle
        step(16'h0, 16'h0, 1'b0, 1'b1);
        step(16'h0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(16'h0, 16'h0, 1'b1, 1'b0);
            chk("idle_grant", grant, 0);
            chk("idle_busy", busy, 0);
            chk("idle_select", select, 0);
            chk("idle_enable", enable, 0);
            chk("idle_ack", ack, 0);
        end
        chk("idle_cap_grant", grant_c, 0);

        // Single packet on port 5, then pointer check via ports 5/6
        step(16'h0020, 16'h0, 1'b1, 1'b0);
        chk("sp_bubble_grant", grant, 0);
        chk("sp_bubble_enable", enable, 0);
        step(16'h0020, 16'h0, 1'b1, 1'b0);
        chk("sp_grant", grant, 16'h0020);
        chk("sp_select", select, 5);
        chk("sp_busy", busy, 1);
        chk("sp_beat1_ack", ack, 16'h0020);
        step(16'h0020, 16'h0, 1'b1, 1'b0);
        chk("sp_beat2_ack", ack, 16'h0020);
        step(16'h0020, 16'h0020, 1'b1, 1'b0);
        chk("sp_beat3_enable", enable, 1);
        step(16'h0060, 16'h0, 1'b1, 1'b0);
        chk("sp_rel_grant", grant, 0);
        chk("sp_rel_busy", busy, 0);
        chk("sp_rel_select_held", select, 5);
        chk("sp_rel_enable", enable, 0);
        step(16'h0060, 16'hFFFF, 1'b1, 1'b0);
        chk("sp_pointer6_grant", grant, 16'h0040);
        chk("sp_pointer6_ack", ack, 16'h0040);
        step(16'h0, 16'h0, 1'b1, 1'b0);
        chk("sp_end_grant", grant, 0);

        // Round-robin fairness from pointer 0
        step(16'h0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(16'h8003, 16'hFFFF, 1'b1, 1'b0);
            chk("rr_bubble_grant", grant, 0);
            chk("rr_bubble_enable", enable, 0);
            step(16'h8003, 16'hFFFF, 1'b1, 1'b0);
            chk("rr_grant", grant, 32'(16'h0001 << rr_order[i]));
            chk("rr_ack", ack, 32'(16'h0001 << rr_order[i]));
        end
        step(16'h0, 16'h0, 1'b1, 1'b0);

        // Backpressure on port 2; last during a stalled cycle is ignored
        step(16'h0004, 16'h0, 1'b0, 1'b0);
        chk("bp_bubble_grant", grant, 0);
        ack_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            step(16'h0004, (k >= 5) ? 16'h0004 : 16'h0000, rdy_pat[k], 1'b0);
            chk("bp_grant_held", grant, 16'h0004);
            chk("bp_ack", ack, rdy_pat[k] ? 16'h0004 : 16'h0000);
            if (ack == 16'h0004) ack_cnt++;
        end
        chk("bp_ack_count", ack_cnt, 4);
        step(16'h0, 16'h0, 1'b1, 1'b0);
        chk("bp_rel_grant", grant, 0);
        chk("bp_rel_busy", busy, 0);

        // Burst cap of 4 on dut_cap; the default instance keeps port 7
        step(16'h0, 16'h0, 1'b1, 1'b1);
        for (int c = 0; c < 12; c++) begin
            step(16'h0180, 16'h0, 1'b1, 1'b0);
            chk("cap_grant", grant_c, cap_exp[c]);
            chk("cap_ack", ack_c, cap_exp[c]);
            chk("nocap_grant", grant, (c == 0) ? 16'h0000 : 16'h0080);
        end

        // Reset mid-packet clears the pointer
        step(16'h0, 16'h0, 1'b1, 1'b1);
        step(16'h0008, 16'hFFFF, 1'b1, 1'b0);
        step(16'h0008, 16'hFFFF, 1'b1, 1'b0);
        chk("rm_first_ack", ack, 16'h0008);
        step(16'h0008, 16'h0, 1'b1, 1'b0);
        step(16'h0008, 16'h0, 1'b1, 1'b0);
        chk("rm_beat1_ack", ack, 16'h0008);
        step(16'h0010, 16'h0010, 1'b1, 1'b0);
        chk("rm_reqdrop_ack", ack, 0);
        chk("rm_reqdrop_grant", grant, 16'h0008);
        step(16'h0008, 16'h0, 1'b1, 1'b0);
        chk("rm_beat2_ack", ack, 16'h0008);
        step(16'h0008, 16'h0, 1'b1, 1'b1);
        step(16'h0, 16'h0, 1'b1, 1'b0);
        chk("rm_grant", grant, 0);
        chk("rm_busy", busy, 0);
        chk("rm_select", select, 0);
        step(16'h0018, 16'h0, 1'b1, 1'b0);
        chk("rm_bubble_grant", grant, 0);
        step(16'h0018, 16'h0, 1'b1, 1'b0);
        chk("rm_rearb_grant", grant, 16'h0008);
        chk("rm_rearb_select", select, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
